// File: rtl/or_window_monitor_pkg.sv
// or_window_monitor shared definitions
// State encodings and default geometry
package or_window_monitor_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_WINDOW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/or_n_way.sv
// or_n_way: N-input OR reduction
// Generalisation of the 8-way OR gate
module or_n_way #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic             y
);

  assign y = |a;

endmodule

// File: rtl/or_window_monitor.sv
// or_window_monitor: windowed OR-reduce status collector
// OR_MON_FIRST_IDX_EN builds the first-set-bit latch
module or_window_monitor
  import or_window_monitor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int IDXW   = $clog2(WIDTH),
  parameter int CNTW   = $clog2(WINDOW + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic             any,
  output logic [WIDTH-1:0] mask,
  output logic [CNTW-1:0]  hits,
  output logic [IDXW-1:0]  first_idx
);

  state_t          state;
  state_t          state_nx;
  logic [CNTW-1:0] cnt;
  logic            nz;
  logic            take;
  logic            last;
  logic            clr;

  or_n_way #(.WIDTH(WIDTH)) u_nz (
    .a (in),
    .y (nz)
  );

  assign clr  = (state == S_IDLE) && start;
  assign take = (state == S_ACCUM) && in_valid;
  assign last = take && (cnt == CNTW'(WINDOW - 1));

  // next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_ACCUM;
      S_ACCUM:  if (last) state_nx = S_REPORT;
      S_REPORT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // accumulators: mask, hit count, sample count
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      mask <= '0;
      hits <= '0;
      cnt  <= '0;
    end else if (take) begin
      mask <= mask | in;
      cnt  <= cnt + 1'b1;
      if (nz) hits <= hits + 1'b1;
    end
  end

  assign busy = (state == S_ACCUM);
  assign done = (state == S_REPORT);
  assign any  = |mask;

`ifdef OR_MON_FIRST_IDX_EN
  logic [IDXW-1:0] enc;

  // lowest set-bit index of the current sample
  always_comb begin
    enc = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (in[i]) enc = IDXW'(i);
  end

  // latch on the first nonzero sample (no prior hits)
  always_ff @(posedge clock) begin
    if (reset || clr)
      first_idx <= '0;
    else if (take && nz && (hits == '0))
      first_idx <= enc;
  end
`else
  assign first_idx = '0;
`endif

endmodule

// File: tb/tb_or_window_monitor.sv
// tb_or_window_monitor: directed vectors, WIDTH=8 WINDOW=4
// Expected first_idx follows OR_MON_FIRST_IDX_EN
module tb_or_window_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in;
  logic       busy;
  logic       done;
  logic       any;
  logic [7:0] mask;
  logic [2:0] hits;
  logic [2:0] first_idx;

  int nvec = 0;
  int nbad = 0;

  or_window_monitor #(.WIDTH(8), .WINDOW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in        (in),
    .busy      (busy),
    .done      (done),
    .any       (any),
    .mask      (mask),
    .hits      (hits),
    .first_idx (first_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samp(input logic [7:0] v);
    in_valid = 1'b1;
    in       = v;
    tick();
    in_valid = 1'b0;
    in       = 8'h00;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [2:0] fi(input logic [2:0] v);
`ifdef OR_MON_FIRST_IDX_EN
    return v;
`else
    return 3'd0;
`endif
  endfunction

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", mask, 0);
    chk("rst_hits", hits, 0);
    chk("rst_fidx", first_idx, 0);
    chk("rst_any", any, 0);

    in_valid = 1'b1;
    in       = 8'hff;
    go();
    in_valid = 1'b0;
    in       = 8'h00;
    chk("s2_busy", busy, 1);
    chk("s2_mask0", mask, 0);
    samp(8'h00);
    samp(8'h10);
    samp(8'h01);
    chk("s2_nodone", done, 0);
    samp(8'h26);
    chk("s2_done", done, 1);
    chk("s2_busy0", busy, 0);
    chk("s2_mask", mask, 8'h37);
    chk("s2_any", any, 1);
    chk("s2_hits", hits, 3);
    chk("s2_fidx", first_idx, fi(3'd4));
    tick();
    chk("s2_pulse", done, 0);
    chk("s2_hold", mask, 8'h37);
    chk("s2_holdh", hits, 3);

    go();
    for (int i = 0; i < 4; i++) begin
      samp(8'h00);
      if (i < 3) begin
        tick();
        chk("s3_gap", done, 0);
        tick();
        chk("s3_gapb", busy, 1);
      end
    end
    chk("s3_done", done, 1);
    chk("s3_any", any, 0);
    chk("s3_hits", hits, 0);
    chk("s3_fidx", first_idx, 0);
    tick();

    go();
    samp(8'h80);
    start = 1'b1;
    samp(8'h00);
    start = 1'b0;
    chk("s4_busy", busy, 1);
    samp(8'h03);
    start = 1'b1;
    tick();
    chk("s4_stall", busy, 1);
    start = 1'b0;
    samp(8'h00);
    chk("s4_done", done, 1);
    chk("s4_mask", mask, 8'h83);
    chk("s4_hits", hits, 2);
    chk("s4_fidx", first_idx, fi(3'd7));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s4_idle", busy, 0);
    chk("s4_nodone", done, 0);
    tick();
    chk("s4_idle2", busy, 0);
    chk("s4_keep", mask, 8'h83);

    go();
    samp(8'h05);
    samp(8'h02);
    chk("s5_mid", mask, 8'h07);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    chk("s5_mask", mask, 0);
    chk("s5_hits", hits, 0);
    chk("s5_fidx", first_idx, 0);
    chk("s5_any", any, 0);
    tick();
    chk("s5_done2", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
